// File: rtl/calc_pkg.sv
// Shared definitions for the calculator key sequencer: keycodes, ALU
// operation encoding, controller states and key classification.
package calc_pkg;

   localparam logic [4:0] KEY_ADD = 5'h0A;
   localparam logic [4:0] KEY_SUB = 5'h0B;
   localparam logic [4:0] KEY_MUL = 5'h0C;
   localparam logic [4:0] KEY_CLR = 5'h0D;
   localparam logic [4:0] KEY_EQ  = 5'h0E;
   localparam logic [4:0] KEY_CE  = 5'h0F;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;

   typedef enum logic [2:0] {
      ENTRY_A,
      ENTRY_B,
      EXEC,
      RESULT,
      ERROR
   } state_e;

   typedef enum logic [2:0] {
      K_NONE,
      K_DIGIT,
      K_OP,
      K_CLR,
      K_EQ,
      K_CE
   } key_e;

   // Codes 0x10-0x1F are not keys and classify as K_NONE.
   function automatic key_e key_class(input logic [4:0] k);
      key_e c;
      if (k[4])
         c = K_NONE;
      else if (k <= 5'h09)
         c = K_DIGIT;
      else begin
         case (k)
            KEY_ADD, KEY_SUB, KEY_MUL: c = K_OP;
            KEY_CLR:                   c = K_CLR;
            KEY_EQ:                    c = K_EQ;
            default:                   c = K_CE;
         endcase
      end
      return c;
   endfunction

   function automatic logic [1:0] key_to_op(input logic [4:0] k);
      logic [1:0] op;
      case (k)
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/calc_entry_reg.sv
// Hex digit entry register: shifts digits in from the right, counts how many
// were accepted and stops accepting once MAX_DIGITS is reached.
module calc_entry_reg #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [3:0]       digit_i,
   output logic [WIDTH-1:0] entry_o,
   output logic             has_digit_o
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   logic [WIDTH-1:0] entry_q, entry_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Clear beats load beats shift; a shift past MAX_DIGITS is dropped.
   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
      if (clr_i) begin
         entry_d = '0;
         cnt_d   = '0;
      end else if (load_i) begin
         entry_d = {{(WIDTH-4){1'b0}}, digit_i};
         cnt_d   = CW'(1);
      end else if (shift_i && (cnt_q < CW'(MAX_DIGITS))) begin
         entry_d = {entry_q[WIDTH-5:0], digit_i};
         cnt_d   = cnt_q + CW'(1);
      end
   end

   // Entry and digit count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         entry_q <= '0;
         cnt_q   <= '0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end

   assign entry_o     = entry_q;
   assign has_digit_o = (cnt_q != '0);

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator controller: collects two operands and an operator from keypad
// strobes, runs one ALU operation at a time over start/done, and drives the
// display value/sign and the overflow indicator.
module calc_key_sequencer
   import calc_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             newkey,
   input  logic [4:0]       keycode,
   output logic             alu_start,
   output logic [1:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_ovf,
   output logic [WIDTH-1:0] value,
   output logic             sign,
   output logic             ovw,
   output logic             busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e                  state_q, state_d;
   logic signed [WIDTH-1:0] acc_q, acc_d;
   logic [1:0]              pend_q, pend_d;
   logic [1:0]              nxt_op_q, nxt_op_d;
   logic                    nxt_vld_q, nxt_vld_d;
   logic [WIDTH-1:0]        a_q, a_d;
   logic [WIDTH-1:0]        b_q, b_d;
   logic [1:0]              aop_q, aop_d;
   logic                    start_q, start_d;
   logic                    ovw_q, ovw_d;
   logic [TW-1:0]           tmo_q, tmo_d;

   logic                    ent_clr, ent_load, ent_shift;
   logic [WIDTH-1:0]        entry;
   logic                    has_digit;
   key_e                    kc;
   logic [1:0]              kop;
   logic                    launch;

   // Magnitude of a two's complement value; the most negative value maps to
   // itself, which reads as 2^(WIDTH-1) when taken as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      return v[WIDTH-1] ? (~u + 1'b1) : u;
   endfunction

   calc_entry_reg #(
      .WIDTH      (WIDTH),
      .MAX_DIGITS (MAX_DIGITS)
   ) u_entry (
      .clk_i       (clock),
      .rst_ni      (resetn),
      .clr_i       (ent_clr),
      .load_i      (ent_load),
      .shift_i     (ent_shift),
      .digit_i     (keycode[3:0]),
      .entry_o     (entry),
      .has_digit_o (has_digit)
   );

   // Next-state logic: clear-all first, then per-state key/ALU handling,
   // then the common launch actions.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      pend_d    = pend_q;
      nxt_op_d  = nxt_op_q;
      nxt_vld_d = nxt_vld_q;
      a_d       = a_q;
      b_d       = b_q;
      aop_d     = aop_q;
      start_d   = 1'b0;
      ovw_d     = ovw_q;
      tmo_d     = tmo_q;
      ent_clr   = 1'b0;
      ent_load  = 1'b0;
      ent_shift = 1'b0;
      launch    = 1'b0;
      kc        = newkey ? key_class(keycode) : K_NONE;
      kop       = key_to_op(keycode);

      if (kc == K_CLR) begin
         // Clear-all wins over everything, including a coincident alu_done.
         state_d   = ENTRY_A;
         acc_d     = '0;
         pend_d    = OP_ADD;
         nxt_op_d  = OP_ADD;
         nxt_vld_d = 1'b0;
         a_d       = '0;
         b_d       = '0;
         aop_d     = OP_ADD;
         ovw_d     = 1'b0;
         tmo_d     = '0;
         ent_clr   = 1'b1;
      end else begin
         case (state_q)
            ENTRY_A: begin
               case (kc)
                  K_DIGIT: ent_shift = 1'b1;
                  K_OP: begin
                     acc_d   = $signed(entry);
                     pend_d  = kop;
                     ent_clr = 1'b1;
                     state_d = ENTRY_B;
                  end
                  K_CE:    ent_clr = 1'b1;
                  default: ;
               endcase
            end
            ENTRY_B: begin
               case (kc)
                  K_DIGIT: ent_shift = 1'b1;
                  K_OP: begin
                     if (has_digit) begin
                        // Chained operator: run the pending op now and
                        // remember this one for the following entry.
                        launch    = 1'b1;
                        nxt_op_d  = kop;
                        nxt_vld_d = 1'b1;
                     end else begin
                        pend_d = kop;
                     end
                  end
                  K_EQ: begin
                     launch    = 1'b1;
                     nxt_vld_d = 1'b0;
                  end
                  K_CE:    ent_clr = 1'b1;
                  default: ;
               endcase
            end
            EXEC: begin
               // Keys other than clear-all are discarded while waiting.
               if (alu_done) begin
                  acc_d = $signed(alu_result);
                  ovw_d = alu_ovf;
                  if (alu_ovf) begin
                     state_d = ERROR;
                  end else if (nxt_vld_q) begin
                     pend_d    = nxt_op_q;
                     nxt_vld_d = 1'b0;
                     ent_clr   = 1'b1;
                     state_d   = ENTRY_B;
                  end else begin
                     state_d = RESULT;
                  end
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  ovw_d   = 1'b1;
                  state_d = ERROR;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
            RESULT: begin
               case (kc)
                  K_OP: begin
                     pend_d  = kop;
                     ent_clr = 1'b1;
                     state_d = ENTRY_B;
                  end
                  K_DIGIT: begin
                     acc_d    = '0;
                     ent_load = 1'b1;
                     state_d  = ENTRY_A;
                  end
                  K_CE:    ent_clr = 1'b1;
                  default: ;
               endcase
            end
            default: ;
         endcase

         if (launch) begin
            a_d     = acc_q;
            b_d     = entry;
            aop_d   = pend_q;
            start_d = 1'b1;
            tmo_d   = '0;
            ent_clr = 1'b1;
            state_d = EXEC;
         end
      end
   end

   // Controller and ALU interface registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ENTRY_A;
         acc_q     <= '0;
         pend_q    <= OP_ADD;
         nxt_op_q  <= OP_ADD;
         nxt_vld_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         aop_q     <= OP_ADD;
         start_q   <= 1'b0;
         ovw_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         pend_q    <= pend_d;
         nxt_op_q  <= nxt_op_d;
         nxt_vld_q <= nxt_vld_d;
         a_q       <= a_d;
         b_q       <= b_d;
         aop_q     <= aop_d;
         start_q   <= start_d;
         ovw_q     <= ovw_d;
         tmo_q     <= tmo_d;
      end
   end

   // Display selection: entry while typing, signed magnitude of the result,
   // blank in ERROR.
   always_comb begin
      value = entry;
      sign  = 1'b0;
      case (state_q)
         RESULT: begin
            value = magnitude(acc_q);
            sign  = acc_q[WIDTH-1];
         end
         ERROR: begin
            value = '0;
            sign  = 1'b0;
         end
         default: ;
      endcase
   end

   assign alu_start = start_q;
   assign alu_op    = aop_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign ovw       = ovw_q;
   assign busy      = (state_q == EXEC);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed scenarios plus random key traffic,
// with the bench acting as the ALU and a behavioural model of the keypad
// calculator predicting operands and display contents.
module tb_calc_key_sequencer;
   import calc_pkg::*;

   logic        clock = 1'b0;
   logic        resetn;
   logic        newkey;
   logic [4:0]  keycode;
   logic        alu_start;
   logic [1:0]  alu_op;
   logic [15:0] alu_a, alu_b;
   logic        alu_done;
   logic [15:0] alu_result;
   logic        alu_ovf;
   logic [15:0] value;
   logic        sign, ovw, busy;

   int n_vec = 0;
   int n_bad = 0;

   calc_key_sequencer #(.WIDTH(16), .MAX_DIGITS(4), .TIMEOUT(64)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .newkey     (newkey),
      .keycode    (keycode),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .alu_ovf    (alu_ovf),
      .value      (value),
      .sign       (sign),
      .ovw        (ovw),
      .busy       (busy)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: calculator described by mode letter and plain integers.
   // "A" first entry, "B" second entry, "X" waiting on ALU, "R" result, "E" error.
   string       md;
   int          m_entry, m_ndig, m_acc, m_pend, m_nxt, m_ovw;
   logic [15:0] la, lb;
   logic [1:0]  lop;

   function automatic int sx16(input int v);
      int t;
      t = v & 32'h0000FFFF;
      return (t >= 32768) ? t - 65536 : t;
   endfunction

   function automatic void m_reset();
      md = "A"; m_entry = 0; m_ndig = 0; m_acc = 0; m_pend = 0; m_nxt = -1; m_ovw = 0;
   endfunction

   function automatic void m_digit(input int d);
      if (m_ndig < 4) begin
         m_entry = ((m_entry << 4) | d) & 32'h0000FFFF;
         m_ndig++;
      end
   endfunction

   function automatic bit m_key(input int k);
      bit go = 0;
      if (k == 13) begin m_reset(); return 0; end
      if (k >= 16) return 0;
      if (md == "A") begin
         if (k < 10) m_digit(k);
         else if (k <= 12) begin
            m_acc = sx16(m_entry); m_pend = k - 10; m_entry = 0; m_ndig = 0; md = "B";
         end else if (k == 15) begin m_entry = 0; m_ndig = 0; end
      end else if (md == "B") begin
         if (k < 10) m_digit(k);
         else if (k <= 12) begin
            if (m_ndig > 0) begin go = 1; m_nxt = k - 10; end
            else m_pend = k - 10;
         end else if (k == 14) begin go = 1; m_nxt = -1; end
         else if (k == 15) begin m_entry = 0; m_ndig = 0; end
      end else if (md == "R") begin
         if (k < 10) begin m_acc = 0; m_entry = k; m_ndig = 1; md = "A"; end
         else if (k <= 12) begin m_pend = k - 10; m_entry = 0; m_ndig = 0; md = "B"; end
         else if (k == 15) begin m_entry = 0; m_ndig = 0; end
      end
      if (go) begin
         la = 16'(m_acc); lb = 16'(m_entry); lop = 2'(m_pend);
         m_entry = 0; m_ndig = 0; md = "X";
      end
      return go;
   endfunction

   function automatic void m_done(input int r16, input bit ovf);
      if (md != "X") return;
      m_acc = sx16(r16); m_ovw = ovf;
      if (ovf) md = "E";
      else if (m_nxt >= 0) begin
         m_pend = m_nxt; m_nxt = -1; m_entry = 0; m_ndig = 0; md = "B";
      end else md = "R";
   endfunction

   function automatic int m_val();
      if (md == "R") return (m_acc < 0) ? -m_acc : m_acc;
      if (md == "E") return 0;
      return m_entry;
   endfunction

   function automatic int alu_ref(input int a, input int b, input int op);
      if (op == 0) return a + b;
      if (op == 1) return a - b;
      return a * b;
   endfunction

   task automatic check_disp(input bit with_busy);
      if (md != "X") begin
         chk("value", 32'(value), 32'(m_val()));
         chk("sign", 32'(sign), 32'((md == "R" && m_acc < 0) ? 1 : 0));
      end
      chk("ovw", 32'(ovw), 32'((md == "E") ? 1 : m_ovw));
      if (with_busy) chk("busy", 32'(busy), 32'((md == "X") ? 1 : 0));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_value"}, 32'(value), 0);
      chk({tag, "_sign"}, 32'(sign), 0);
      chk({tag, "_ovw"}, 32'(ovw), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_start"}, 32'(alu_start), 0);
      chk({tag, "_a"}, 32'(alu_a), 0);
      chk({tag, "_b"}, 32'(alu_b), 0);
      chk({tag, "_op"}, 32'(alu_op), 0);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic press(input logic [4:0] k, output bit launched);
      newkey = 1'b1; keycode = k;
      @(negedge clock);
      newkey = 1'b0; keycode = 5'($urandom);
      launched = m_key(int'(k));
   endtask

   task automatic serve_alu(input int dly);
      int  r;
      bit  ovf, l;
      chk("start", 32'(alu_start), 1);
      chk("alu_a", 32'(alu_a), 32'(la));
      chk("alu_b", 32'(alu_b), 32'(lb));
      chk("alu_op", 32'(alu_op), 32'(lop));
      @(negedge clock);
      chk("start_pulse", 32'(alu_start), 0);
      chk("busy_exec", 32'(busy), 1);
      for (int i = 0; i < dly; i++) begin
         if ($urandom_range(0, 1) == 1) press(5'($urandom_range(0, 12)), l);
         else @(negedge clock);
      end
      chk("hold_a", 32'(alu_a), 32'(la));
      chk("hold_b", 32'(alu_b), 32'(lb));
      r   = alu_ref(sx16(int'(la)), sx16(int'(lb)), int'(lop));
      ovf = (r > 32767) || (r < -32768);
      alu_result = 16'(r); alu_ovf = ovf; alu_done = 1'b1;
      if ($urandom_range(0, 3) == 0) begin newkey = 1'b1; keycode = 5'($urandom_range(0, 9)); end
      @(negedge clock);
      alu_done = 1'b0; newkey = 1'b0;
      m_done(r & 32'h0000FFFF, ovf);
      check_disp(1'b0);
   endtask

   task automatic key(input logic [4:0] k);
      bit l;
      press(k, l);
      if (l) serve_alu($urandom_range(0, 4));
      else check_disp(1'b1);
   endtask

   task automatic launch_only(input logic [4:0] k1, input logic [4:0] k2);
      bit l;
      key(k1); key(KEY_ADD); key(k2);
      press(KEY_EQ, l);
      chk("launch", 32'(l), 1);
      chk("launch_start", 32'(alu_start), 1);
   endtask

   initial begin
      bit l;
      int p;
      logic [4:0] k;
      resetn = 1'b0; newkey = 1'b0; keycode = '0;
      alu_done = 1'b0; alu_result = '0; alu_ovf = 1'b0;
      m_reset();
      repeat (2) @(negedge clock);
      check_zero("reset");
      resetn = 1'b1;
      @(negedge clock);
      check_disp(1'b1);

      // 0x12 + 3
      key(5'h1); key(5'h2); key(KEY_ADD); key(5'h3); key(KEY_EQ);
      chk("add_value", 32'(value), 32'h15);
      chk("add_sign", 32'(sign), 0);
      chk("add_ovw", 32'(ovw), 0);

      // Fifth digit ignored
      key(5'h1); key(5'h2); key(5'h3); key(5'h4); key(5'h5);
      chk("maxdig", 32'(value), 32'h1234);
      key(5'h13);
      chk("ignored_code", 32'(value), 32'h1234);
      key(KEY_CE); key(5'h7);
      chk("clear_entry", 32'(value), 32'h7);
      key(KEY_CLR);

      // 5 - 9 = -4
      key(5'h5); key(KEY_SUB); key(5'h9); key(KEY_EQ);
      chk("neg_value", 32'(value), 32'h4);
      chk("neg_sign", 32'(sign), 1);

      // Operator replacement, then chaining 2+3 then *4
      key(KEY_CLR); key(5'h2); key(KEY_SUB); key(KEY_ADD); key(5'h3);
      press(KEY_MUL, l);
      chk("chain1_op", 32'(alu_op), 0);
      serve_alu(2);
      key(5'h4);
      press(KEY_EQ, l);
      chk("chain2_a", 32'(alu_a), 5);
      chk("chain2_b", 32'(alu_b), 4);
      chk("chain2_op", 32'(alu_op), 2);
      serve_alu(1);
      chk("chain_value", 32'(value), 20);

      // Most negative value: 0x8000 + 0
      key(KEY_CLR); key(5'h8); key(5'h0); key(5'h0); key(5'h0);
      key(KEY_ADD); key(5'h0); key(KEY_EQ);
      chk("minneg_value", 32'(value), 32'h8000);
      chk("minneg_sign", 32'(sign), 1);

      // Multiply overflow -> ERROR
      key(KEY_CLR); key(5'h2); key(5'h0); key(5'h0); key(KEY_MUL);
      key(5'h2); key(5'h0); key(5'h0); key(KEY_EQ);
      chk("ovf_ovw", 32'(ovw), 1);
      chk("ovf_value", 32'(value), 0);
      key(KEY_CLR);

      // Timeout
      launch_only(5'h1, 5'h2);
      repeat (50) @(negedge clock);
      chk("tmo_wait_busy", 32'(busy), 1);
      chk("tmo_wait_ovw", 32'(ovw), 0);
      repeat (20) @(negedge clock);
      md = "E"; m_ovw = 1;
      chk("tmo_ovw", 32'(ovw), 1);
      chk("tmo_value", 32'(value), 0);
      chk("tmo_busy", 32'(busy), 0);
      key(5'h3);
      chk("err_digit", 32'(value), 0);
      chk("err_digit_ovw", 32'(ovw), 1);
      key(KEY_CLR);
      check_zero("err_clear");

      // Clear during EXEC, late done ignored
      launch_only(5'h4, 5'h5);
      key(KEY_CLR);
      alu_result = 16'h0009; alu_ovf = 1'b0; alu_done = 1'b1;
      @(negedge clock);
      alu_done = 1'b0;
      m_done(9, 1'b0);
      check_zero("late_done");
      key(5'h6);
      chk("after_late", 32'(value), 6);
      key(KEY_CLR);

      // Clear and done in the same cycle: clear wins
      launch_only(5'h3, 5'h3);
      @(negedge clock);
      newkey = 1'b1; keycode = KEY_CLR;
      alu_result = 16'h1234; alu_ovf = 1'b0; alu_done = 1'b1;
      @(negedge clock);
      newkey = 1'b0; alu_done = 1'b0;
      m_reset();
      check_zero("clr_vs_done");

      // Asynchronous reset in EXEC
      launch_only(5'h4, 5'h1);
      #2 resetn = 1'b0;
      #1 check_zero("async_rst");
      @(negedge clock);
      resetn = 1'b1;
      m_reset();
      @(negedge clock);
      check_disp(1'b1);

      // Random key traffic
      for (int i = 0; i < 300; i++) begin
         p = $urandom_range(0, 99);
         if (p < 50)      k = 5'($urandom_range(0, 9));
         else if (p < 70) k = 5'($urandom_range(10, 12));
         else if (p < 85) k = KEY_EQ;
         else if (p < 90) k = KEY_CE;
         else if (p < 95) k = KEY_CLR;
         else             k = 5'($urandom_range(16, 31));
         key(k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
